fp_seq_multiplier: RTL and testbench
====================================

Name: fp_seq_multiplier

Overview:
Multi-cycle IEEE-754 single-precision multiplier. It is the inverse-direction companion to the FPU's Newton-Raphson divider.
- Computes a_operand × b_operand with a 24-iteration shift-add mantissa datapath instead of a combinational array.
- Sits in the FPU beside the combinational units for area-constrained builds (e.g. neuron cores).
- Uses a valid/ready handshake on both input and output.

Parameters:
MANT_W, 24, significand width including hidden bit; sets iteration count.
EXP_BIAS, 127, exponent bias.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a_operand  input  32  IEEE-754 single operand A.
b_operand  input  32  IEEE-754 single operand B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  32  product.
Exception  output  1  either operand exponent field is 8'hFF.
Overflow  output  1  product exponent exceeded 254.
Underflow  output  1  product exponent below 1 with nonzero operands.

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RESET.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, Exception=0, Overflow=0, Underflow=0, counter=0, product=0.
- RESET has priority in every state. Asserting it mid-operation discards the operation; no out_valid is produced for it.
- States: IDLE, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge (accept edge k), latch: sign = a[31]^b[31]; mA={1,a[22:0]}; mB={1,b[22:0]}.
  - Also latch the 10-bit signed exponent sum ea+eb-EXP_BIAS.
  - Also latch the flags: exc = (&a[30:23])|(&b[30:23]); zero = (a[30:23]==0)|(b[30:23]==0). Denormals are flushed to zero.
  - Clear product and counter. Go to MUL.
- MUL:
  - Each edge: if mB[counter], product += mA<<counter (48-bit, no truncation); counter++.
  - After counter reaches 23 (24 iterations, edges k+1..k+24), go to NORM.
- NORM (edge k+25):
  - If product[47]: mant=product[46:24], exp+=1. Else mant=product[45:23]. Rounding is truncation (round toward zero).
  - Result priority:
    - exc → result=32'h7FC00000, Exception=1.
    - else zero → result={sign,31'b0}.
    - else exp>254 → result={sign,8'hFF,23'b0}, Overflow=1.
    - else exp<1 → result={sign,31'b0}, Underflow=1.
    - else result={sign,exp[7:0],mant}.
  - Set out_valid=1. Go to DONE.
- Latency: fixed 25 edges from accept to out_valid visible, for all operand classes including special cases.
- DONE:
  - result and flags are held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid=0, flags cleared, go to IDLE. in_ready=1 the following cycle; no same-cycle re-accept.
- in_valid outside IDLE is ignored; operands are not sampled. Input operand changes after acceptance have no effect.
- Flags are only meaningful while out_valid=1.
- Throughput: one result per 27 cycles minimum.

Test Plan:
1. Reset, then a=32'h40000000 (2.0), b=32'h40400000 (3.0), out_ready=1 → out_valid asserted 25 edges after accept; result=32'h40C00000; all flags 0.
2. a=32'h3FC00000 (1.5), b=32'hC0200000 (-2.5) → result=32'hC0700000 (-3.75); then a=32'h3F800000 × b=32'h3F800000 → 32'h3F800000, exercising the product[47]=0 normalisation path.
3. a=32'h00000000, b=32'h42F60000 → result=32'h00000000. a=32'h80000000, b=32'h3F800000 → result=32'h80000000.
4. a=32'h7F800000, b=32'h3F800000 → Exception=1, result=32'h7FC00000. a=32'h7F000000, b=32'h40000000 → Overflow=1, result=32'h7F800000. a=32'h00800000, b=32'h00800000 → Underflow=1, result=32'h00000000.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid → result and flags stable, in_ready=0, new in_valid ignored. Raise out_ready → out_valid drops next edge; in_ready=1 one cycle later.
6. Assert RESET at cycle 10 of MUL → next cycle state IDLE, in_ready=1, out_valid=0. A fresh 2.0×3.0 then yields 32'h40C00000 with the nominal 25-edge latency.

Source files
------------

// File: rtl/fp_seq_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier with a shift-add
// significand datapath and valid/ready handshakes on input and output.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for operands, in_ready high
// MUL    | one shift-add step per cycle over all MANT_W multiplier bits
// NORM   | normalise, classify, register result and flags
// DONE   | result presented with out_valid until out_ready
module fp_seq_multiplier #(
  parameter int MANT_W   = 24,
  parameter int EXP_BIAS = 127
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int CNT_W  = $clog2(MANT_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MANT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic                r_sign;
  logic                r_exc;
  logic                r_zero;
  logic [9:0]          r_exp;
  logic [MANT_W-1:0]   r_mant_a;
  logic [MANT_W-1:0]   r_mant_b;
  logic [PROD_W-1:0]   r_product;
  logic [CNT_W-1:0]    r_count;
  logic [31:0]         r_result;
  logic                r_exc_flag;
  logic                r_ovf_flag;
  logic                r_unf_flag;

  logic [9:0]          w_exp_sum;
  logic [PROD_W-1:0]   w_addend;
  logic [MANT_W-2:0]   w_mant;
  logic [9:0]          w_exp_norm;
  logic [31:0]         w_result_next;
  logic                w_exc_next;
  logic                w_ovf_next;
  logic                w_unf_next;

  // Exponent sum is kept as 10-bit two's complement so it can go below 1
  // or above 254 without wrapping into a legal-looking value.
  assign w_exp_sum = {2'b00, a_operand[30:23]} + {2'b00, b_operand[30:23]}
                     - 10'(EXP_BIAS);
  assign w_addend  = {{MANT_W{1'b0}}, r_mant_a} << r_count;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign Exception = r_exc_flag;
  assign Overflow  = r_ovf_flag;
  assign Underflow = r_unf_flag;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = S_MUL;
      S_MUL:  if (r_count == LAST_CNT) w_state_next = S_NORM;
      S_NORM: w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Normalisation (truncating) and result classification in priority order.
  always_comb begin
    w_mant        = r_product[PROD_W-3 -: MANT_W-1];
    w_exp_norm    = r_exp;
    w_result_next = 32'h0;
    w_exc_next    = 1'b0;
    w_ovf_next    = 1'b0;
    w_unf_next    = 1'b0;
    if (r_product[PROD_W-1]) begin
      w_mant     = r_product[PROD_W-2 -: MANT_W-1];
      w_exp_norm = r_exp + 10'd1;
    end
    if (r_exc) begin
      w_result_next = 32'h7FC00000;
      w_exc_next    = 1'b1;
    end else if (r_zero) begin
      w_result_next = {r_sign, 31'b0};
    end else if ($signed(w_exp_norm) > 10'sd254) begin
      w_result_next = {r_sign, 8'hFF, 23'b0};
      w_ovf_next    = 1'b1;
    end else if ($signed(w_exp_norm) < 10'sd1) begin
      w_result_next = {r_sign, 31'b0};
      w_unf_next    = 1'b1;
    end else begin
      w_result_next = {r_sign, w_exp_norm[7:0], w_mant};
    end
  end

  // Operand capture, shift-add iterations and result/flag registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sign     <= 1'b0;
      r_exc      <= 1'b0;
      r_zero     <= 1'b0;
      r_exp      <= '0;
      r_mant_a   <= '0;
      r_mant_b   <= '0;
      r_product  <= '0;
      r_count    <= '0;
      r_result   <= '0;
      r_exc_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
      r_unf_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign    <= a_operand[31] ^ b_operand[31];
            r_mant_a  <= {1'b1, a_operand[22:0]};
            r_mant_b  <= {1'b1, b_operand[22:0]};
            r_exp     <= w_exp_sum;
            r_exc     <= (&a_operand[30:23]) | (&b_operand[30:23]);
            r_zero    <= (a_operand[30:23] == 8'h00) | (b_operand[30:23] == 8'h00);
            r_product <= '0;
            r_count   <= '0;
          end
        end
        S_MUL: begin
          if (r_mant_b[r_count]) r_product <= r_product + w_addend;
          r_count <= r_count + 1'b1;
        end
        S_NORM: begin
          r_result   <= w_result_next;
          r_exc_flag <= w_exc_next;
          r_ovf_flag <= w_ovf_next;
          r_unf_flag <= w_unf_next;
        end
        S_DONE: begin
          if (out_ready) begin
            r_exc_flag <= 1'b0;
            r_ovf_flag <= 1'b0;
            r_unf_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Directed bench for fp_seq_multiplier: hand-computed products, special
// cases, backpressure and mid-operation reset.
module tb_fp_seq_multiplier;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_operand = 32'h0;
  logic [31:0] b_operand = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;

  int n_chk  = 0;
  int n_pass = 0;

  fp_seq_multiplier dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation and wait for out_valid; leaves the result presented
  // (out_ready low) so the caller decides when to complete the handshake.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int n;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    a_operand = 32'hDEADBEEF;
    b_operand = 32'h12345678;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd25);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_flags"}, {29'b0, Exception, Overflow, Underflow}, {29'b0, exp_flags});
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_flags_clr"}, {29'b0, Exception, Overflow, Underflow}, 32'd0);
    chk({tag, "_rdy_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags);
    issue(tag, a, b, exp_res, exp_flags);
    finish_hs(tag);
  endtask

  initial begin
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'b0, Exception, Overflow, Underflow}, 32'd0);

    // flags order: {Exception, Overflow, Underflow}
    run_op("2x3",      32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    run_op("1p5xm2p5", 32'h3FC00000, 32'hC0200000, 32'hC0700000, 3'b000);
    run_op("1x1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
    run_op("zero",     32'h00000000, 32'h42F60000, 32'h00000000, 3'b000);
    run_op("negzero",  32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    run_op("inf",      32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b100);
    run_op("ovf",      32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
    run_op("unf",      32'h00800000, 32'h00800000, 32'h00000000, 3'b001);

    // Backpressure: result held, new operands ignored while in DONE.
    issue("bp", 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    a_operand = 32'h7F800000;
    b_operand = 32'h7F800000;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_result", result, 32'h40C00000);
      chk("bp_hold_flags", {29'b0, Exception, Overflow, Underflow}, 32'd0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finish_hs("bp");

    // Reset during MUL discards the operation.
    a_operand = 32'h40000000;
    b_operand = 32'h40400000;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'h0);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (out_valid) seen++;
      end
      chk("midrst_no_valid", seen, 32'd0);
    end
    run_op("post_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
